// File: rtl/alu_exec_unit.sv
// alu_exec_unit
//   Execution unit feeding the Z result register of the multicycle CPU
//   datapath. Operand A is held in the Y register and operand B comes from
//   the shared bus when `start` is accepted. Logic/arithmetic ops finish
//   in one step. MULU, DIVU and REMU iterate 32 times.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   bus_data        shared CPU bus (Y load data and operand B)
//   yin             load bus_data into Y
//   start, op       begin operation op (accepted only when idle)
//   alu_out         registered result, held between completions
//   zin_o, done     one-cycle completion strobes (zin_o = Z write enable)
//   busy            operation in flight, through the done cycle
//   zero, ovf, dz   result flags, updated together with alu_out
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] bus_data,
  input  logic             yin,
  input  logic             start,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] alu_out,
  output logic             zin_o,
  output logic             done,
  output logic             busy,
  output logic             zero,
  output logic             ovf,
  output logic             dz
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4, OP_SLL = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7;
  localparam logic [3:0] OP_SLT = 4'd8, OP_MUL = 4'd9, OP_DIV = 4'd10, OP_REM = 4'd11;

  logic [1:0]         state_reg;
  logic [WIDTH-1:0]   y_reg, a_reg, b_reg;
  logic [3:0]         op_reg;
  logic [SW-1:0]      cnt_reg;
  logic [2*WIDTH-1:0] acc_reg;     // MUL: product; DIV: {remainder, quotient}
  logic [2*WIDTH-1:0] mcand_reg;   // MUL: multiplicand shifted left each step
  logic [WIDTH-1:0]   mplier_reg;  // MUL: multiplier shifted right each step
  logic               dz_pend_reg;

  // Start acceptance decoding
  logic start_ok, is_iter, is_div_zero;
  assign start_ok    = start && (state_reg == S_IDLE);
  assign is_div_zero = ((op == OP_DIV) || (op == OP_REM)) && (bus_data == '0);
  assign is_iter     = ((op == OP_MUL) || (op == OP_DIV) || (op == OP_REM)) && !is_div_zero;

  // Single-cycle datapath
  logic [WIDTH-1:0] sum, diff, single_res;
  logic [SW-1:0]    shamt;
  assign sum   = a_reg + b_reg;
  assign diff  = a_reg - b_reg;
  assign shamt = b_reg[SW-1:0];

  always_comb begin
    single_res = '0;
    case (op_reg)
      OP_ADD: single_res = sum;
      OP_SUB: single_res = diff;
      OP_AND: single_res = a_reg & b_reg;
      OP_OR:  single_res = a_reg | b_reg;
      OP_XOR: single_res = a_reg ^ b_reg;
      OP_SLL: single_res = a_reg << shamt;
      OP_SRL: single_res = a_reg >> shamt;
      OP_SRA: single_res = $unsigned($signed(a_reg) >>> shamt);
      OP_SLT: single_res = {{(WIDTH-1){1'b0}}, ($signed(a_reg) < $signed(b_reg))};
      default: single_res = '0;
    endcase
  end

  // Signed overflow: operands agree in sign (after negating B for SUB)
  // but the result sign differs.
  logic add_ovf, sub_ovf;
  assign add_ovf = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (sum[WIDTH-1]  != a_reg[WIDTH-1]);
  assign sub_ovf = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) && (diff[WIDTH-1] != a_reg[WIDTH-1]);

  // Iteration step. The shifted partial remainder needs WIDTH+1 bits
  // because it may reach just under 2*B before the trial subtraction.
  logic [2*WIDTH-1:0] mul_next, div_next;
  logic [WIDTH:0]     rem_shift, rem_trial;
  logic               rem_ge;
  assign mul_next  = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;
  assign rem_shift = acc_reg[2*WIDTH-1:WIDTH-1];
  assign rem_trial = rem_shift - {1'b0, b_reg};
  assign rem_ge    = (rem_shift >= {1'b0, b_reg});
  assign div_next  = rem_ge ? {rem_trial[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1}
                            : {rem_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};

  // Final result selection
  logic [WIDTH-1:0] final_res;
  always_comb begin
    final_res = single_res;
    case (op_reg)
      OP_MUL: final_res = acc_reg[WIDTH-1:0];
      OP_DIV: final_res = dz_pend_reg ? {WIDTH{1'b1}} : acc_reg[WIDTH-1:0];
      OP_REM: final_res = dz_pend_reg ? a_reg : acc_reg[2*WIDTH-1:WIDTH];
      default: final_res = single_res;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      y_reg       <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      op_reg      <= '0;
      cnt_reg     <= '0;
      acc_reg     <= '0;
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      dz_pend_reg <= 1'b0;
      alu_out     <= '0;
      zin_o       <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
      zero        <= 1'b0;
      ovf         <= 1'b0;
      dz          <= 1'b0;
    end else begin
      // Y is independent of the FSM; A is snapped from the old Y on start.
      if (yin) y_reg <= bus_data;
      done  <= 1'b0;
      zin_o <= 1'b0;

      case (state_reg)
        S_IDLE: begin
          // busy still covers the done cycle (spent here), then drops
          // unless a new operation is accepted at this same edge.
          busy <= start_ok;
          if (start_ok) begin
            a_reg       <= y_reg;
            b_reg       <= bus_data;
            op_reg      <= op;
            cnt_reg     <= '0;
            dz_pend_reg <= is_div_zero;
            mcand_reg   <= {{WIDTH{1'b0}}, y_reg};
            mplier_reg  <= bus_data;
            acc_reg     <= (op == OP_MUL) ? '0 : {{WIDTH{1'b0}}, y_reg};
            state_reg   <= is_iter ? S_RUN : S_FINISH;
          end
        end
        S_RUN: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (op_reg == OP_MUL) begin
            acc_reg    <= mul_next;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
          end else begin
            acc_reg <= div_next;
          end
          if (cnt_reg == SW'(WIDTH-1)) state_reg <= S_FINISH;
        end
        S_FINISH: begin
          alu_out   <= final_res;
          zero      <= (final_res == '0);
          ovf       <= ((op_reg == OP_ADD) && add_ovf) || ((op_reg == OP_SUB) && sub_ovf);
          dz        <= dz_pend_reg;
          done      <= 1'b1;
          zin_o     <= 1'b1;
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] bus_data = '0;
  logic        yin = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  op = '0;
  logic [31:0] alu_out;
  logic        zin_o, done, busy, zero, ovf, dz;

  int checks = 0;
  int failures = 0;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .bus_data(bus_data), .yin(yin), .start(start), .op(op),
    .alu_out(alu_out), .zin_o(zin_o), .done(done), .busy(busy),
    .zero(zero), .ovf(ovf), .dz(dz)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Load Y with a, start op o with B=b, wait (bounded) for done.
  // lat = edges after the accepting edge until done is seen.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] o, output int lat);
    yin = 1'b1; bus_data = a;
    tick();
    yin = 1'b0; bus_data = b; start = 1'b1; op = o;
    tick();
    start = 1'b0; bus_data = '0;
    lat = 0;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    $display("op=%0d a=0x%08h b=0x%08h -> alu_out=0x%08h zero=%0b ovf=%0b dz=%0b lat=%0d",
             o, a, b, alu_out, zero, ovf, dz, lat);
  endtask

  int lat;
  int busy_bad;
  int early_done;
  int late_done;

  initial begin
    // Reset
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_alu_out", alu_out, 32'h0);
    chk("rst_flags", {26'b0, zin_o, done, busy, zero, ovf, dz}, 32'h0);

    // ADD 0+0
    do_op(32'h0, 32'h0, 4'd0, lat);
    chk("add0_lat", lat, 1);
    chk("add0_res", alu_out, 32'h0);
    chk("add0_zero", zero, 1);

    // ADD overflow, one-cycle zin_o
    do_op(32'h7FFF_FFFF, 32'h1, 4'd0, lat);
    chk("addovf_lat", lat, 1);
    chk("addovf_res", alu_out, 32'h8000_0000);
    chk("addovf_ovf", ovf, 1);
    chk("addovf_zin", zin_o, 1);
    tick();
    chk("addovf_zin_off", {zin_o, done}, 2'b00);
    chk("addovf_hold", alu_out, 32'h8000_0000);

    // SRA
    do_op(32'h8000_0000, 32'd4, 4'd7, lat);
    chk("sra_res", alu_out, 32'hF800_0000);
    chk("sra_ovf", ovf, 0);

    // SLT signed: -1 < 1
    do_op(32'hFFFF_FFFF, 32'd1, 4'd8, lat);
    chk("slt_res", alu_out, 32'd1);

    // MULU with interfering yin at N+5 and start at N+10
    yin = 1'b1; bus_data = 32'h0001_2345;
    tick();
    yin = 1'b0; bus_data = 32'h0001_0000; start = 1'b1; op = 4'd9;
    tick();
    start = 1'b0; bus_data = '0;
    busy_bad = 0;
    early_done = 0;
    for (int c = 1; c <= 33; c++) begin
      if (c == 5)  begin yin = 1'b1; bus_data = 32'hDEAD_BEEF; end
      if (c == 6)  begin yin = 1'b0; bus_data = '0; end
      if (c == 10) begin start = 1'b1; op = 4'd0; bus_data = 32'h5; end
      if (c == 11) begin start = 1'b0; bus_data = '0; end
      tick();
      if (!busy) busy_bad++;
      if (c < 33 && done) early_done++;
    end
    $display("op=9 a=0x00012345 b=0x00010000 -> alu_out=0x%08h done=%0b", alu_out, done);
    chk("mul_busy", busy_bad, 0);
    chk("mul_early_done", early_done, 0);
    chk("mul_done", done, 1);
    chk("mul_res", alu_out, 32'h2345_0000);
    tick();
    chk("mul_no_queue", {busy, done}, 2'b00);

    // DIVU / REMU
    do_op(32'd100, 32'd7, 4'd10, lat);
    chk("divu_lat", lat, 33);
    chk("divu_res", alu_out, 32'd14);
    chk("divu_dz", dz, 0);
    do_op(32'd100, 32'd7, 4'd11, lat);
    chk("remu_lat", lat, 33);
    chk("remu_res", alu_out, 32'd2);

    // Divide by zero
    do_op(32'd100, 32'd0, 4'd10, lat);
    chk("div0_lat", lat, 1);
    chk("div0_res", alu_out, 32'hFFFF_FFFF);
    chk("div0_dz", dz, 1);
    do_op(32'd100, 32'd0, 4'd11, lat);
    chk("rem0_res", alu_out, 32'd100);

    // Reset mid-MULU
    yin = 1'b1; bus_data = 32'd9;
    tick();
    yin = 1'b0; bus_data = 32'd9; start = 1'b1; op = 4'd9;
    tick();
    start = 1'b0; bus_data = '0;
    repeat (14) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_out", alu_out, 32'h0);
    chk("midrst_busy", {busy, done, zin_o}, 3'b000);
    late_done = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (done || busy) late_done++;
    end
    $display("mid-op reset: later done/busy cycles=%0d", late_done);
    chk("midrst_no_done", late_done, 0);

    // ADD 3+4 after abort
    do_op(32'd3, 32'd4, 4'd0, lat);
    chk("add34_lat", lat, 1);
    chk("add34_res", alu_out, 32'd7);
    chk("add34_zero", zero, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
